// File: rtl/four_full_add.sv
// four_full_add: 4-bit ripple-carry adder built from four full-adder cells.
// Registered sum/carry/overflow with a valid flag, or purely combinational when REG_OUT=0.
module four_full_add #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       ovf,
    output logic       valid
);
    logic [4:0] c;
    logic [3:0] s;
    logic [5:0] res;
    assign c[0] = cin;
    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate
    // Packed as {ovf, cout, s3..s0}; signed overflow is carry-in vs carry-out of the MSB.
    assign res = {c[3] ^ c[4], c[4], s};
    generate
        if (REG_OUT) begin : g_reg
            logic [5:0] q;
            logic       v;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                    v <= 1'b0;
                end else begin
                    v <= en;
                    if (en) q <= res;
                end
            end
            assign {ovf, cout, s3, s2, s1, s0} = q;
            assign valid = v;
        end else begin : g_comb
            assign {ovf, cout, s3, s2, s1, s0} = res;
            assign valid = 1'b1;
        end
    endgenerate
endmodule

// File: tb/tb_four_full_add.sv
// tb_four_full_add: randomized and directed checks of the registered nibble adder
// against an arithmetic reference model.
module tb_four_full_add;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic       cout, s0, s1, s2, s3, ovf, valid;
    logic [6:0] obs;
    logic [6:0] exp_v;
    logic [5:0] last;
    int total = 0;
    int bad = 0;

    four_full_add #(.REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .cin(cin),
        .cout(cout), .s0(s0), .s1(s1), .s2(s2), .s3(s3), .ovf(ovf), .valid(valid)
    );

    always #5 clk = ~clk;
    assign obs = {valid, ovf, cout, s3, s2, s1, s0};

    // Reference: {ovf, 5-bit unsigned sum} from integer arithmetic.
    function automatic logic [5:0] model(input int x, input int y, input int ci);
        int u, sx, sy, ss;
        logic [31:0] uv;
        u  = x + y + ci;
        uv = u;
        sx = (x > 7) ? x - 16 : x;
        sy = (y > 7) ? y - 16 : y;
        ss = sx + sy + ci;
        return {(ss > 7 || ss < -8), uv[4:0]};
    endfunction

    task automatic step(input logic [3:0] na, input logic [3:0] nb, input logic nc, input logic ne);
        @(negedge clk);
        a = na; b = nb; cin = nc; en = ne;
        @(posedge clk);
        #1;
        if (ne) last = model(int'(na), int'(nb), int'(nc));
        exp_v = {ne, last};
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; a = 4'b0101; b = 4'b1111; cin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (obs !== 7'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", k, obs, 7'd0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        last = '0;
    endtask

    task automatic test_directed;
        logic [3:0] ta [4] = '{4'b0000, 4'b0101, 4'b0101, 4'b1001};
        logic [3:0] tb [4] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000};
        logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [6:0] want [4] = '{7'b1_0_0_0000, 7'b1_0_0_0101, 7'b1_0_0_1110, 7'b1_1_1_0010};
        for (int k = 0; k < 4; k++) begin
            step(ta[k], tb[k], tc[k], 1'b1);
            total++;
            if (obs !== want[k] || obs !== exp_v) begin
                bad++;
                $display("FAIL directed_%0d got=%b want=%b model=%b", k, obs, want[k], exp_v);
            end
        end
    endtask

    task automatic test_hold;
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        total++;
        if (obs !== 7'b0_1_1_0010) begin
            bad++;
            $display("FAIL hold got=%b want=%b", obs, 7'b0_1_1_0010);
        end
        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        total++;
        if (obs !== 7'b1_0_1_1111) begin
            bad++;
            $display("FAIL hold_release got=%b want=%b", obs, 7'b1_0_1_1111);
        end
    endtask

    task automatic test_sweep;
        for (int k = 0; k < 512; k++) begin
            step(k[3:0], k[7:4], k[8], 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL sweep a=%0d b=%0d cin=%0d got=%b want=%b", k[3:0], k[7:4], k[8], obs, exp_v);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 300; k++) begin
            step(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL random_%0d got=%b want=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset;
        step(4'b1001, 4'b1000, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 7'd0) begin
            bad++;
            $display("FAIL async_clear got=%b want=%b", obs, 7'd0);
        end
        #1;
        rst = 1'b0;
        last = '0;
        @(posedge clk);
        #1;
        last = model(9, 8, 1);
        total++;
        if (obs !== {1'b1, last}) begin
            bad++;
            $display("FAIL post_reset_capture got=%b want=%b", obs, {1'b1, last});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_sweep();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/four_full_add.md
Name:
four_full_add

Overview:
- 4-bit ripple-carry adder built from four 1-bit full-adder cells.
- Computes a + b + cin; the sum is exported as four separate bit outputs plus carry-out.
- Results are captured in an output register stage clocked by the system clock.
- Serves as the small arithmetic primitive for datapath blocks that need a registered nibble add with explicit carry chaining.

Parameters:
- REG_OUT, default 1: 1 = outputs registered (1-cycle latency); 0 = outputs driven combinationally, clk/rst/en have no effect on the sum path.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable for the output register.
- a  input  4  addend A, unsigned (also interpreted as two's complement for ovf).
- b  input  4  addend B.
- cin  input  1  carry into bit 0.
- cout  output  1  carry out of bit 3.
- s0  output  1  sum bit 0 (LSB).
- s1  output  1  sum bit 1.
- s2  output  1  sum bit 2.
- s3  output  1  sum bit 3 (MSB).
- ovf  output  1  signed overflow: carry into bit 3 XOR carry out of bit 3.
- valid  output  1  high for one cycle following each cycle where en was high (REG_OUT=1); constant 1 when REG_OUT=0.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Ripple chain, one full-adder cell per bit i:
  - s_i = a[i] ^ b[i] ^ c_i
  - c_(i+1) = a[i]&b[i] | c_i&(a[i]^b[i])
  - c_0 = cin; cout = c_4; ovf = c_3 ^ c_4.
- {cout,s3,s2,s1,s0} equals the 5-bit value a + b + cin in all 512 input combinations; max result 15+15+1 = 31 = 1_1111.
- REG_OUT=1:
  - Rising clk with en=1: register captures cout, s3..s0, ovf from the current inputs; valid <= 1.
  - Rising clk with en=0: sum/cout/ovf registers hold; valid <= 0.
  - Latency from input change to output = 1 clock edge.
- Reset: while rst=1, immediately and independent of clk, cout=0, s3..s0=0, ovf=0, valid=0. Assertion mid-operation discards any pending capture.
- First capture after reset deassertion occurs on the first rising clk with rst=0 and en=1.
- REG_OUT=0: outputs follow inputs combinationally, zero latency; reset does not force outputs.
- No X propagation from en/rst when inputs are known; no internal state besides the output register and valid flag.

Test Plan:
- Assert rst, drive a=0101 b=1111 cin=1 with en=1 and toggle clk -> all outputs 0, valid 0 throughout reset.
- Release rst; a=0000 b=0000 cin=0, en=1, one edge -> s3..s0=0000, cout=0, ovf=0, valid=1.
- a=0101 b=0000 cin=0 -> after one edge s3..s0=0101, cout=0, ovf=0.
- a=0101 b=1000 cin=1 -> s3..s0=1110, cout=0, ovf=0; then a=1001 b=1000 cin=1 -> s3..s0=0010, cout=1, ovf=1.
- Hold with en=0 while changing inputs to a=1111 b=1111 cin=1 -> outputs keep the previous value, valid=0; then en=1 -> s3..s0=1111, cout=1, ovf=0.
- Exhaustive sweep of all 512 combinations with en=1 -> {cout,s3..s0} == a+b+cin one cycle later; pulse rst between two edges -> outputs clear asynchronously before the next edge.
